// File: rtl/glitch_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : glitch_pulse_gen
// Purpose  : Timing engine behind the UART command handler. On a pulse_en or
//            reset_en strobe it snapshots the configuration, optionally holds
//            the target in reset, waits the programmed delay and then emits a
//            train of glitch pulses. All timing is in clk cycles.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            delay_i             - cycles from trigger/reset release to pulse 1
//            width_i             - active cycles per pulse
//            num_pulses_i        - pulses in the train
//            pulse_spacing_i     - idle cycles between pulses
//            reset_length_i      - target reset hold time
//            pulse_en_i          - strobe: start the pulse train
//            reset_en_i          - strobe: reset target, then pulse train
//            glitch_o            - glitch output (registered)
//            target_rst_o        - reset to the target (registered)
//            busy_o              - sequence in progress
//            done_o              - one-cycle end-of-sequence strobe
// Revision : 1.0 - initial release
// ============================================================================
module glitch_pulse_gen #(
    parameter logic GLITCH_IDLE = 1'b0,
    parameter logic TRST_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] delay_i,
    input  logic [7:0]  width_i,
    input  logic [7:0]  num_pulses_i,
    input  logic [15:0] pulse_spacing_i,
    input  logic [15:0] reset_length_i,
    input  logic        pulse_en_i,
    input  logic        reset_en_i,
    output logic        glitch_o,
    output logic        target_rst_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RESET    = 3'd1,
        S_DELAY    = 3'd2,
        S_PULSE_HI = 3'd3,
        S_PULSE_LO = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t      r_state;

    // Configuration snapshot. The reset length is snapshotted straight into
    // the shared 16-bit timer, since it is only needed at acceptance.
    logic [15:0] r_delay;
    logic [7:0]  r_width;
    logic [7:0]  r_num;
    logic [15:0] r_spacing;

    // r_tmr serves reset length, delay and spacing (never two at once).
    logic [15:0] r_tmr;
    logic [7:0]  r_wcnt;
    logic [7:0]  r_pulses;

    logic        r_glitch;
    logic        r_trst;
    logic        r_busy;
    logic        r_done;

    // A reset strobe with zero length degenerates to the plain pulse path.
    logic        w_do_reset;
    assign w_do_reset = reset_en_i && (reset_length_i != 16'd0);

    // Launch of the delay/pulse phase happens either straight from IDLE (use
    // the live inputs, the snapshot is being written on the same edge) or at
    // the end of RESET (use the snapshot).
    logic        w_from_idle;
    logic [15:0] w_src_delay;
    logic [7:0]  w_src_width;
    logic [7:0]  w_src_num;

    assign w_from_idle = (r_state == S_IDLE);
    assign w_src_delay = w_from_idle ? delay_i      : r_delay;
    assign w_src_width = w_from_idle ? width_i      : r_width;
    assign w_src_num   = w_from_idle ? num_pulses_i : r_num;

    state_t      w_l_state;
    logic [15:0] w_l_tmr;
    logic [7:0]  w_l_wcnt;
    logic [7:0]  w_l_pulses;
    logic        w_l_glitch;
    logic        w_l_done;

    always_comb begin
        w_l_state  = S_DELAY;
        w_l_tmr    = w_src_delay - 16'd1;
        w_l_wcnt   = 8'd0;
        w_l_pulses = 8'd0;
        w_l_glitch = GLITCH_IDLE;
        w_l_done   = 1'b0;
        if (w_src_delay == 16'd0) begin
            w_l_tmr = 16'd0;
            if ((w_src_width == 8'd0) || (w_src_num == 8'd0)) begin
                // Empty train: finish immediately.
                w_l_state = S_DONE;
                w_l_done  = 1'b1;
            end else begin
                w_l_state  = S_PULSE_HI;
                w_l_wcnt   = w_src_width - 8'd1;
                w_l_pulses = w_src_num;
                w_l_glitch = ~GLITCH_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_delay   <= 16'd0;
            r_width   <= 8'd0;
            r_num     <= 8'd0;
            r_spacing <= 16'd0;
            r_tmr     <= 16'd0;
            r_wcnt    <= 8'd0;
            r_pulses  <= 8'd0;
            r_glitch  <= GLITCH_IDLE;
            r_trst    <= ~TRST_ACTIVE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pulse_en_i || reset_en_i) begin
                        r_delay   <= delay_i;
                        r_width   <= width_i;
                        r_num     <= num_pulses_i;
                        r_spacing <= pulse_spacing_i;
                        r_busy    <= 1'b1;
                        if (w_do_reset) begin
                            r_state <= S_RESET;
                            r_trst  <= TRST_ACTIVE;
                            r_tmr   <= reset_length_i - 16'd1;
                        end else begin
                            r_state  <= w_l_state;
                            r_tmr    <= w_l_tmr;
                            r_wcnt   <= w_l_wcnt;
                            r_pulses <= w_l_pulses;
                            r_glitch <= w_l_glitch;
                            r_done   <= w_l_done;
                        end
                    end
                end
                S_RESET: begin
                    if (r_tmr == 16'd0) begin
                        r_trst   <= ~TRST_ACTIVE;
                        r_state  <= w_l_state;
                        r_tmr    <= w_l_tmr;
                        r_wcnt   <= w_l_wcnt;
                        r_pulses <= w_l_pulses;
                        r_glitch <= w_l_glitch;
                        r_done   <= w_l_done;
                    end else begin
                        r_tmr <= r_tmr - 16'd1;
                    end
                end
                S_DELAY: begin
                    if (r_tmr == 16'd0) begin
                        if ((r_width == 8'd0) || (r_num == 8'd0)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= S_PULSE_HI;
                            r_wcnt   <= r_width - 8'd1;
                            r_pulses <= r_num;
                            r_glitch <= ~GLITCH_IDLE;
                        end
                    end else begin
                        r_tmr <= r_tmr - 16'd1;
                    end
                end
                S_PULSE_HI: begin
                    if (r_wcnt == 8'd0) begin
                        if (r_pulses != 8'd0) begin
                            r_pulses <= r_pulses - 8'd1;
                        end
                        if (r_pulses <= 8'd1) begin
                            r_state  <= S_DONE;
                            r_glitch <= GLITCH_IDLE;
                            r_done   <= 1'b1;
                        end else if (r_spacing == 16'd0) begin
                            // Zero spacing: pulses merge, output stays active.
                            r_wcnt <= r_width - 8'd1;
                        end else begin
                            r_state  <= S_PULSE_LO;
                            r_tmr    <= r_spacing - 16'd1;
                            r_glitch <= GLITCH_IDLE;
                        end
                    end else begin
                        r_wcnt <= r_wcnt - 8'd1;
                    end
                end
                S_PULSE_LO: begin
                    if (r_tmr == 16'd0) begin
                        r_state  <= S_PULSE_HI;
                        r_wcnt   <= r_width - 8'd1;
                        r_glitch <= ~GLITCH_IDLE;
                    end else begin
                        r_tmr <= r_tmr - 16'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_glitch <= GLITCH_IDLE;
                    r_trst   <= ~TRST_ACTIVE;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign glitch_o     = r_glitch;
    assign target_rst_o = r_trst;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_glitch_pulse_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_glitch_pulse_gen
// Purpose  : Self-checking bench for glitch_pulse_gen. Directed vectors with
//            hand-computed waveforms (bit k of a mask = active in cycle k after
//            the strobe cycle), plus hand-written reset-mid-sequence cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_glitch_pulse_gen;

    localparam logic C_GI = 1'b0;
    localparam logic C_TA = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] delay_i;
    logic [7:0]  width_i;
    logic [7:0]  num_pulses_i;
    logic [15:0] pulse_spacing_i;
    logic [15:0] reset_length_i;
    logic        pulse_en_i;
    logic        reset_en_i;
    logic        glitch_o;
    logic        target_rst_o;
    logic        busy_o;
    logic        done_o;

    glitch_pulse_gen #(
        .GLITCH_IDLE (C_GI),
        .TRST_ACTIVE (C_TA)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .delay_i         (delay_i),
        .width_i         (width_i),
        .num_pulses_i    (num_pulses_i),
        .pulse_spacing_i (pulse_spacing_i),
        .reset_length_i  (reset_length_i),
        .pulse_en_i      (pulse_en_i),
        .reset_en_i      (reset_en_i),
        .glitch_o        (glitch_o),
        .target_rst_o    (target_rst_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_en;
        logic        pls_en;
        logic [15:0] delay;
        logic [7:0]  width;
        logic [7:0]  num;
        logic [15:0] spacing;
        logic [15:0] rlen;
        logic        disturb;   // fire strobes and change inputs mid-sequence
        logic [63:0] g_mask;    // cycles with glitch active
        logic [63:0] r_mask;    // cycles with target reset active
        int          done_cyc;  // cycle carrying done_o
    } vec_t;

    vec_t vecs[9];
    int   errors = 0;
    int   checks = 0;

    task automatic check4(input string name, input int cyc,
                          input logic [3:0] exp);
        logic [3:0] act;
        act = {glitch_o, target_rst_o, busy_o, done_o};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: {glitch,trst,busy,done} got %b expected %b",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] idle_exp();
        return {C_GI, ~C_TA, 1'b0, 1'b0};
    endfunction

    task automatic run_vec(input int idx);
        vec_t       v;
        logic [3:0] exp;
        v = vecs[idx];
        @(negedge clk);
        delay_i         = v.delay;
        width_i         = v.width;
        num_pulses_i    = v.num;
        pulse_spacing_i = v.spacing;
        reset_length_i  = v.rlen;
        pulse_en_i      = v.pls_en;
        reset_en_i      = v.rst_en;
        for (int k = 1; k <= v.done_cyc + 1; k++) begin
            @(negedge clk);
            pulse_en_i = 1'b0;
            reset_en_i = 1'b0;
            exp[3] = v.g_mask[k] ? ~C_GI : C_GI;
            exp[2] = v.r_mask[k] ? C_TA : ~C_TA;
            exp[1] = (k <= v.done_cyc);
            exp[0] = (k == v.done_cyc);
            check4(v.name, k, exp);
            if (v.disturb && k == 3) begin
                pulse_en_i      = 1'b1;
                reset_en_i      = 1'b1;
                width_i         = 8'd7;
                delay_i         = 16'd0;
                num_pulses_i    = 8'd5;
                pulse_spacing_i = 16'd0;
                reset_length_i  = 16'd9;
            end
        end
    endtask

    initial begin
        //              name        rst pls delay  w     n     S      L      dist g_mask         r_mask        done
        vecs[0] = '{"basic",      0, 1, 16'd5, 8'd3, 8'd2, 16'd4, 16'd0,  0, 64'h0000_E1C0, 64'h0,       16};
        vecs[1] = '{"reset_path", 1, 0, 16'd2, 8'd1, 8'd1, 16'd0, 16'd10, 0, 64'h0000_2000, 64'h0000_07FE, 14};
        vecs[2] = '{"merge",      0, 1, 16'd0, 8'd2, 8'd3, 16'd0, 16'd0,  0, 64'h0000_007E, 64'h0,        7};
        vecs[3] = '{"num_zero",   0, 1, 16'd4, 8'd3, 8'd0, 16'd2, 16'd0,  0, 64'h0,         64'h0,        5};
        vecs[4] = '{"both_strb",  1, 1, 16'd1, 8'd2, 8'd2, 16'd1, 16'd3,  0, 64'h0000_0360, 64'h0000_000E, 10};
        vecs[5] = '{"rst_len0",   1, 0, 16'd2, 8'd1, 8'd2, 16'd2, 16'd0,  0, 64'h0000_0048, 64'h0,        7};
        vecs[6] = '{"width_zero", 0, 1, 16'd0, 8'd0, 8'd3, 16'd1, 16'd0,  0, 64'h0,         64'h0,        1};
        vecs[7] = '{"rst_d0",     1, 0, 16'd0, 8'd1, 8'd1, 16'd0, 16'd2,  0, 64'h0000_0008, 64'h0000_0006, 4};
        vecs[8] = '{"busy_ign",   0, 1, 16'd5, 8'd3, 8'd2, 16'd4, 16'd0,  1, 64'h0000_E1C0, 64'h0,       16};

        rst             = 1'b1;
        delay_i         = 16'd0;
        width_i         = 8'd0;
        num_pulses_i    = 8'd0;
        pulse_spacing_i = 16'd0;
        reset_length_i  = 16'd0;
        pulse_en_i      = 1'b0;
        reset_en_i      = 1'b0;
        repeat (3) @(negedge clk);
        check4("reset_state", 0, idle_exp());
        rst = 1'b0;
        @(negedge clk);
        check4("post_reset_idle", 0, idle_exp());

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
        end

        // rst asserted while the target is held in reset.
        @(negedge clk);
        delay_i         = 16'd2;
        width_i         = 8'd1;
        num_pulses_i    = 8'd1;
        pulse_spacing_i = 16'd0;
        reset_length_i  = 16'd10;
        reset_en_i      = 1'b1;
        @(negedge clk);
        reset_en_i = 1'b0;
        check4("rst_in_reset_pre", 1, {C_GI, C_TA, 1'b1, 1'b0});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check4("rst_in_reset", 5, idle_exp());
        rst = 1'b0;
        @(negedge clk);
        check4("rst_in_reset_stay", 6, idle_exp());
        run_vec(0);

        // rst asserted while a pulse is active.
        @(negedge clk);
        delay_i         = 16'd5;
        width_i         = 8'd3;
        num_pulses_i    = 8'd2;
        pulse_spacing_i = 16'd4;
        reset_length_i  = 16'd0;
        pulse_en_i      = 1'b1;
        @(negedge clk);
        pulse_en_i = 1'b0;
        repeat (6) @(negedge clk);
        check4("rst_in_pulse_pre", 7, {~C_GI, ~C_TA, 1'b1, 1'b0});
        rst = 1'b1;
        @(negedge clk);
        check4("rst_in_pulse", 8, idle_exp());
        rst = 1'b0;
        run_vec(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/glitch_pulse_gen.md
Name: glitch_pulse_gen

Overview:
- Timing engine directly downstream of the UART command handler.
- Consumes the handler's configuration registers and its one-cycle pulse_en / reset_en strobes.
- Optionally holds the target in reset, then waits a programmed delay and emits a train of glitch pulses on the glitch output.
- All timing is in clk cycles; the configuration is snapshotted when a strobe is accepted.

Parameters:
- GLITCH_IDLE, 1'b0, idle level of glitch_o; the active pulse level is the inverse.
- TRST_ACTIVE, 1'b1, asserted level of target_rst_o.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- delay_i  input  16  cycles from trigger (or reset release) to the first pulse
- width_i  input  8  high time of each pulse, in cycles
- num_pulses_i  input  8  number of pulses in the train
- pulse_spacing_i  input  16  low cycles between consecutive pulses
- reset_length_i  input  16  target reset hold time, in cycles
- pulse_en_i  input  1  one-cycle strobe: start the pulse train
- reset_en_i  input  1  one-cycle strobe: reset the target, then start the pulse train
- glitch_o  output  1  glitch pulse output
- target_rst_o  output  1  reset to the device under test
- busy_o  output  1  high while a sequence is running
- done_o  output  1  one-cycle strobe when a sequence finishes

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: glitch_o=GLITCH_IDLE, target_rst_o=!TRST_ACTIVE, busy_o=0, done_o=0, state=IDLE, all counters and snapshot registers 0.
- States: IDLE, RESET, DELAY, PULSE_HI, PULSE_LO, DONE.
- Strobe acceptance: strobes are sampled only in IDLE and ignored in any other state (no queuing).
- Snapshot: on acceptance, delay, width, num_pulses, spacing and reset_length are latched. Input changes mid-sequence have no effect.
- Priority: if both strobes are high in the same cycle, reset_en_i wins. reset_en_i with reset_length_i=0 behaves exactly like pulse_en_i.
- Timing (strobe high in cycle 0, L=reset_length, D=delay, W=width, N=num_pulses, S=spacing):
  - busy_o is high from cycle 1 through the DONE cycle inclusive.
  - RESET: target_rst_o is active in cycles 1..L; it is released in cycle L+1.
  - DELAY: D cycles. D=0 means no delay cycles.
  - First pulse: glitch_o goes active in cycle L+D+1 (pulse path: D+1).
  - Each pulse is active for W cycles. Between pulses, glitch_o is idle for S cycles. No spacing follows the last pulse.
  - S=0: consecutive pulses merge into one contiguous active period of N*W cycles.
  - DONE: lasts one cycle, starting the cycle after the last active cycle. done_o=1 and busy_o=1 in that cycle; the next state is IDLE.
  - A new strobe is accepted in the cycle after DONE at the earliest.
- Degenerate cases: N=0 or W=0 means glitch_o never goes active. The delay is still counted, then DONE follows immediately after it (in cycle L+D+1).
- Counters:
  - 16-bit down-counters handle delay, spacing and reset length; an 8-bit counter handles width.
  - An 8-bit pulses-remaining counter decrements at the end of each PULSE_HI.
  - No wrap-around: each counter is loaded before use and stops at terminal count.
- Outputs: all outputs are registered; glitch_o and target_rst_o are driven straight from flops (glitch-free).
- rst mid-sequence: all outputs return to their reset values on the next edge; target_rst_o is released immediately.

Test Plan:
- Basic train: rst, then width=3, num=2, spacing=4, delay=5, pulse_en in cycle 0 -> glitch active in cycles 6-8 and 13-15; done_o in cycle 16; busy_o high in cycles 1-16.
- Reset path: reset_length=10, delay=2, width=1, num=1, reset_en in cycle 0 -> target_rst_o active in cycles 1-10; glitch active in cycle 13; done_o in cycle 14.
- Zero/merge cases:
  - delay=0, spacing=0, width=2, num=3 -> glitch active in cycles 1-6 continuously.
  - num=0, delay=4 -> glitch never active; done_o in cycle 5.
- Busy and priority:
  - pulse_en issued mid-sequence and width_i changed mid-sequence -> ignored; timing unchanged.
  - pulse_en and reset_en in the same cycle -> reset path taken.
- Reset mid-sequence: assert rst during RESET and during PULSE_HI -> next cycle glitch_o idle, target_rst_o inactive, busy_o=0; a following pulse_en produces correct timing.
